// File: rtl/subn_soma.sv
// Spiking soma: evaluates the summed synapse potential against an adaptive
// threshold, emits a one-cycle spike, then holds off for a refractory period.
module subn_soma #(
    parameter int p_width = 8,
    parameter int p_shift = 8,
    parameter logic [p_width+p_shift+3:0] p_thr_init = 20'h08000,
    parameter logic [p_width+p_shift+3:0] p_thr_min  = 20'h00400,
    parameter int p_thr_dec      = 1,
    parameter int p_decay_period = 256,
    parameter int p_refract      = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic [9:0]                     i_sync,
    input  logic [p_width+p_shift+3:0]     i_s,
    input  logic                           i_reward,
    output logic                           o_spike,
    output logic                           o_busy,
    output logic [p_width+p_shift+3:0]     o_potential,
    output logic [p_width+p_shift+3:0]     o_thr
);

    localparam int W   = p_width + p_shift + 4;
    localparam int DCW = $clog2(p_decay_period);
    localparam int RCW = $clog2(p_refract + 1);

    localparam logic [W-1:0]   THR_DEC   = W'(p_thr_dec);
    localparam logic [W:0]     DEC_LIMIT = {1'b0, p_thr_min} + {1'b0, THR_DEC};
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(p_decay_period - 1);
    localparam logic [RCW-1:0] RCNT_LOAD = RCW'(p_refract);

    // state   | meaning
    // IDLE    | waiting for an enabled sync strobe
    // EVAL    | capture i_s, compare against threshold
    // FIRE    | spike cycle, optional reward load of threshold
    // REFRACT | hold-off, syncs dropped
    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_FIRE,
        S_REFRACT
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pot_q, pot_d;
    logic [W-1:0]   thr_q, thr_d;
    logic [W-1:0]   thr_decayed;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           tick;
    logic           spike;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pot_q   <= '0;
            thr_q   <= p_thr_init;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            thr_q   <= thr_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign tick   = (dcnt_q == DCNT_LAST);
    assign dcnt_d = tick ? '0 : dcnt_q + DCW'(1);

    // Thresholds already under the floor (reward-loaded) are left alone.
    always_comb begin
        thr_decayed = thr_q;
        if ({1'b0, thr_q} >= DEC_LIMIT) begin
            thr_decayed = thr_q - THR_DEC;
        end else if (thr_q >= p_thr_min) begin
            thr_decayed = p_thr_min;
        end
    end

    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        thr_d   = tick ? thr_decayed : thr_q;
        rcnt_d  = rcnt_q;
        spike   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((i_sync != '0) && i_en) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                pot_d   = i_s;
                state_d = (i_s >= thr_q) ? S_FIRE : S_IDLE;
            end
            S_FIRE: begin
                spike   = 1'b1;
                // reward load overrides a coincident decay tick
                if (i_reward) begin
                    thr_d = pot_q;
                end
                rcnt_d  = RCNT_LOAD;
                state_d = S_REFRACT;
            end
            S_REFRACT: begin
                rcnt_d = rcnt_q - RCW'(1);
                if (rcnt_q <= RCW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_spike     = spike;
    assign o_busy      = (state_q != S_IDLE);
    assign o_potential = pot_q;
    assign o_thr       = thr_q;

endmodule

// File: tb/tb_subn_soma.sv
// Directed bench for subn_soma: vector table plus hand-written timing,
// decay, reset and enable sequences.
module tb_subn_soma;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [9:0]   sync;
    logic [W-1:0] s;
    logic         reward;
    logic         spike, busy;
    logic [W-1:0] pot, thr;

    logic         en2;
    logic [9:0]   sync2;
    logic         spike2, busy2;
    logic [W-1:0] pot2, thr2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    subn_soma #(
        .p_width(8), .p_shift(8),
        .p_thr_init(20'h08000), .p_thr_min(20'h00400),
        .p_thr_dec(1), .p_decay_period(256), .p_refract(4)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sync(sync), .i_s(s),
        .i_reward(reward), .o_spike(spike), .o_busy(busy),
        .o_potential(pot), .o_thr(thr)
    );

    subn_soma #(
        .p_width(8), .p_shift(8),
        .p_thr_init(20'h00402), .p_thr_min(20'h00400),
        .p_thr_dec(1), .p_decay_period(256), .p_refract(4)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en2), .i_sync(sync2), .i_s(s),
        .i_reward(reward), .o_spike(spike2), .o_busy(busy2),
        .o_potential(pot2), .o_thr(thr2)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         rew;
        logic         fire;
        logic [W-1:0] thr_after;
    } vec_t;

    vec_t vecs[8];

    // cyc equals the number of edges since the last reset edge,
    // so cyc % 256 is the decay-counter phase.
    task automatic step();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; sync = '0; en = 1'b1; reward = 1'b0; s = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && busy; i++) step();
        chk({name, " return to idle"}, busy, 0);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 2000 && cyc < target; i++) step();
        chk("cycle alignment", cyc, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{20'h09000, 1'b0, 1'b1, 20'h08000};
        vecs[1] = '{20'h07FFF, 1'b0, 1'b0, 20'h08000};
        vecs[2] = '{20'h08000, 1'b0, 1'b1, 20'h08000};
        vecs[3] = '{20'h07FFF, 1'b1, 1'b0, 20'h08000};
        vecs[4] = '{20'h0C000, 1'b1, 1'b1, 20'h0C000};
        vecs[5] = '{20'h0BFFF, 1'b0, 1'b0, 20'h0C000};
        vecs[6] = '{20'hFFFFF, 1'b1, 1'b1, 20'hFFFFF};
        vecs[7] = '{20'hFFFFF, 1'b0, 1'b1, 20'hFFFFF};

        en2 = 1'b0; sync2 = '0;
        do_reset();
        chk("reset spike", spike, 0);
        chk("reset busy", busy, 0);
        chk("reset potential", pot, 0);
        chk("reset thr", thr, 20'h08000);

        // single fire, busy for EVAL + FIRE + 4 REFRACT
        s = 20'h09000; sync = 10'b0000000100;
        step();
        chk("t1 eval spike", spike, 0);
        chk("t1 eval busy", busy, 1);
        sync = '0;
        step();
        chk("t1 fire spike", spike, 1);
        chk("t1 potential", pot, 20'h09000);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1 refract busy", busy, 1);
            chk("t1 refract spike", spike, 0);
        end
        step();
        chk("t1 idle busy", busy, 0);
        chk("t1 thr", thr, 20'h08000);

        for (int v = 0; v < 8; v++) begin
            s = vecs[v].s; reward = vecs[v].rew; sync = 10'b0000000100;
            step();
            chk($sformatf("vec%0d eval busy", v), busy, 1);
            sync = '0;
            step();
            chk($sformatf("vec%0d spike", v), spike, vecs[v].fire);
            chk($sformatf("vec%0d potential", v), pot, vecs[v].s);
            chk($sformatf("vec%0d busy after eval", v), busy, vecs[v].fire);
            wait_idle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d thr", v), thr, vecs[v].thr_after);
        end
        reward = 1'b0;

        // reward load coinciding with decay tick, then a normal tick
        do_reset();
        wait_cyc(253);
        s = 20'h0A000; reward = 1'b1; sync = 10'b0000000001;
        step();
        sync = '0;
        step();
        chk("t3 fire spike", spike, 1);
        chk("t3 thr before load", thr, 20'h08000);
        step();
        chk("t3 reward beats tick", thr, 20'h0A000);
        reward = 1'b0;
        wait_cyc(511);
        chk("t3 thr before tick", thr, 20'h0A000);
        step();
        chk("t3 thr after tick", thr, 20'h09FFF);

        // reset during REFRACT
        s = 20'h0A000; reward = 1'b1; sync = 10'b0000000001;
        step();
        sync = '0;
        step();
        step();
        chk("t6 in refract", busy, 1);
        chk("t6 thr loaded", thr, 20'h0A000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6r spike", spike, 0);
        chk("t6r busy", busy, 0);
        chk("t6r potential", pot, 0);
        chk("t6r thr", thr, 20'h08000);
        step();
        chk("t6r busy later", busy, 0);

        // reset during FIRE: no reward load, no further spike
        s = 20'h09000; reward = 1'b1; sync = 10'b0000000001;
        step();
        sync = '0;
        step();
        chk("t6f fire spike", spike, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6f spike", spike, 0);
        chk("t6f busy", busy, 0);
        chk("t6f potential", pot, 0);
        chk("t6f thr", thr, 20'h08000);
        reward = 1'b0;

        // reset during EVAL: no spike afterwards
        sync = 10'b0000000001;
        step();
        sync = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6e spike", spike, 0);
        step();
        chk("t6e spike later", spike, 0);
        chk("t6e busy later", busy, 0);

        // enable low blocks evaluation
        en = 1'b0; sync = 10'h3FF; s = 20'hFFFFF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en0 busy", busy, 0);
        end
        // enable falling mid-evaluation does not abort
        en = 1'b1;
        step();
        en = 1'b0; sync = '0;
        step();
        chk("en drop spike", spike, 1);
        wait_idle("en drop");
        en = 1'b1;

        // continuous syncs: spikes every 7 cycles, extras dropped
        do_reset();
        s = 20'h09000; sync = 10'b1000000000;
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k == 20) sync = '0;
            chk($sformatf("t5 spike k=%0d", k), spike, (k == 2 || k == 9 || k == 16));
            chk($sformatf("t5 busy k=%0d", k), busy, !(k == 7 || k == 14 || k >= 21));
        end

        // decay to floor on the second instance
        do_reset();
        begin
            int           tgt[6];
            logic [W-1:0] exp_thr[6];
            tgt = '{255, 256, 511, 512, 767, 1280};
            exp_thr = '{20'h00402, 20'h00401, 20'h00401, 20'h00400, 20'h00400, 20'h00400};
            for (int i = 0; i < 6; i++) begin
                wait_cyc(tgt[i]);
                chk($sformatf("t4 thr at %0d", tgt[i]), thr2, exp_thr[i]);
            end
            chk("t4 busy2", busy2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
